// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder: write-type codes,
// FSM state encoding, default geometry and byte-lane helpers.
package data_mem_responder_pkg;

    localparam int DEFAULT_DEPTH   = 32;
    localparam int DEFAULT_LATENCY = 3;

    typedef enum logic [1:0] {
        WT_WORD = 2'd0,
        WT_HALF = 2'd1,
        WT_BYTE = 2'd2,
        WT_RSVD = 2'd3
    } wr_type_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_READ_WAIT  = 2'd1,
        ST_WRITE_WAIT = 2'd2,
        ST_DRAIN      = 2'd3
    } state_t;

    // Little-endian byte lanes touched by a store; reserved type touches none.
    function automatic logic [3:0] lane_mask(input wr_type_t t, input logic [1:0] lo);
        logic [3:0] m;
        m = 4'b0000;
        case (t)
            WT_WORD: m = 4'b1111;
            WT_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
            WT_BYTE: m = 4'b0001 << lo;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replicate right-aligned store data across lanes so the mask alone selects.
    function automatic logic [31:0] lane_data(input wr_type_t t, input logic [31:0] d);
        logic [31:0] r;
        case (t)
            WT_HALF: r = {2{d[15:0]}};
            WT_BYTE: r = {4{d[7:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic misaligned(input wr_type_t t, input logic [1:0] lo);
        logic m;
        case (t)
            WT_WORD: m = (lo != 2'b00);
            WT_HALF: m = lo[0];
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage with per-byte write enables; zeroed by synchronous reset.
// Combinational read port, write takes effect at the rising edge.
module data_mem_array
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_word,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_word
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (wr_en[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    assign rd_word = mem[rd_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory for load unit and ROB commit; one access at a time,
// done pulse LATENCY cycles after acceptance. DATA_MEM_ALIGN_CHECK_EN adds alignErr.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rdReq,
    input  logic [31:0] rdAddr,
    input  logic        wrReq,
    input  logic [31:0] wrAddr,
    input  logic [31:0] wrData,
    input  logic [1:0]  wrType,
    output logic [31:0] rdData,
    output logic        rdDone,
    output logic        wrDone,
`ifdef DATA_MEM_ALIGN_CHECK_EN
    output logic        alignErr,
`endif
    output logic        busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    wr_type_t    type_q;
    logic        op_wr_q;
    logic        mis;
    logic        exec;
    logic [3:0]  mem_we;
    logic [IDX_W-1:0] idx;
    logic [31:0] rd_word;

    // Out-of-range word addresses alias back into the array.
    assign idx = IDX_W'({2'b00, addr_q[31:2]} % DEPTH);

`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic align_q;
    assign mis      = misaligned(op_wr_q ? type_q : WT_WORD, addr_q[1:0]);
    assign alignErr = align_q;
`else
    assign mis = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (wrReq) begin
                    state_nxt = ST_WRITE_WAIT;
                end else if (rdReq) begin
                    state_nxt = ST_READ_WAIT;
                end
            end
            ST_READ_WAIT, ST_WRITE_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Only the completed requester's line releases the FSM.
                if (op_wr_q ? !wrReq : !rdReq) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != ST_IDLE);
        exec   = ((state == ST_READ_WAIT) || (state == ST_WRITE_WAIT)) && (cnt == '0);
        mem_we = 4'b0000;
        if (exec && (state == ST_WRITE_WAIT) && !mis) begin
            mem_we = lane_mask(type_q, addr_q[1:0]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            type_q  <= WT_WORD;
            op_wr_q <= 1'b0;
            rdData  <= '0;
            rdDone  <= 1'b0;
            wrDone  <= 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
            align_q <= 1'b0;
`endif
        end else begin
            rdDone <= 1'b0;
            wrDone <= 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
            align_q <= 1'b0;
`endif
            if (state == ST_IDLE) begin
                if (wrReq) begin
                    addr_q  <= wrAddr;
                    data_q  <= wrData;
                    type_q  <= wr_type_t'(wrType);
                    op_wr_q <= 1'b1;
                    cnt     <= CNT_LOAD;
                end else if (rdReq) begin
                    addr_q  <= rdAddr;
                    op_wr_q <= 1'b0;
                    cnt     <= CNT_LOAD;
                end
            end else if (exec) begin
`ifdef DATA_MEM_ALIGN_CHECK_EN
                align_q <= mis;
`endif
                if (state == ST_WRITE_WAIT) begin
                    wrDone <= 1'b1;
                end else begin
                    rdDone <= 1'b1;
                    rdData <= mis ? 32'h0 : rd_word;
                end
            end else if (state != ST_DRAIN) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    data_mem_array #(.DEPTH(DEPTH)) u_array (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (mem_we),
        .wr_idx  (idx),
        .wr_word (lane_data(type_q, data_q)),
        .rd_idx  (idx),
        .rd_word (rd_word)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench with a byte-array model and transaction-window timing expectations.
module tb_data_mem_responder;

    localparam int DEPTH = 32;
    localparam int LAT   = 3;

    logic        clock  = 1'b0;
    logic        reset  = 1'b0;
    logic        rdReq  = 1'b0;
    logic [31:0] rdAddr = '0;
    logic        wrReq  = 1'b0;
    logic [31:0] wrAddr = '0;
    logic [31:0] wrData = '0;
    logic [1:0]  wrType = '0;
    logic [31:0] rdData;
    logic        rdDone;
    logic        wrDone;
    logic        busy;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic        alignErr;
`endif

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clock  (clock),
        .reset  (reset),
        .rdReq  (rdReq),
        .rdAddr (rdAddr),
        .wrReq  (wrReq),
        .wrAddr (wrAddr),
        .wrData (wrData),
        .wrType (wrType),
        .rdData (rdData),
        .rdDone (rdDone),
        .wrDone (wrDone),
`ifdef DATA_MEM_ALIGN_CHECK_EN
        .alignErr (alignErr),
`endif
        .busy   (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rst_seen = 1'b0;

    // Transaction windows: accepted at *_acc, done pulse at *_done, busy through *_end.
    int w_acc = -1, w_done = -1, w_end = -1;
    int r_acc = -1, r_done = -1, r_end = -1;
    logic [31:0] w_addr = '0, w_data = '0, r_addr = '0;
    logic [1:0]  w_type = '0;

    logic [7:0]  mb [DEPTH*4];
    logic [31:0] exp_rd = '0;

    always @(posedge clock) begin
        cyc = cyc + 1;
        rst_seen = !reset;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic bit is_mis(input bit is_wr, input logic [1:0] t, input logic [31:0] a);
`ifdef DATA_MEM_ALIGN_CHECK_EN
        if (!is_wr || t == 2'd0) return (a[1:0] != 2'b00);
        if (t == 2'd1) return a[0];
        return 1'b0;
`else
        return 1'b0 & is_wr & t[0] & a[0];
`endif
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        int base;
        int lane;
        base = widx(a) * 4;
        if (is_mis(1'b1, t, a)) return;
        case (t)
            2'd0: for (int b = 0; b < 4; b++) mb[base + b] = d[8*b +: 8];
            2'd1: begin
                lane = a[1] ? 2 : 0;
                mb[base + lane]     = d[7:0];
                mb[base + lane + 1] = d[15:8];
            end
            2'd2: mb[base + int'(a[1:0])] = d[7:0];
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int base;
        base = widx(a) * 4;
        if (is_mis(1'b0, 2'd0, a)) return 32'h0;
        return {mb[base + 3], mb[base + 2], mb[base + 1], mb[base]};
    endfunction

    always @(negedge clock) begin
        bit exp_busy;
        if (cyc >= 1) begin
            if (rst_seen) begin
                for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
                exp_rd = '0;
            end
            if (cyc == w_done) model_write(w_addr, w_data, w_type);
            if (cyc == r_done) exp_rd = model_read(r_addr);
            exp_busy = (cyc >= w_acc && cyc <= w_end) || (cyc >= r_acc && cyc <= r_end);
            chk("busy",   32'(busy),   32'(exp_busy));
            chk("rdDone", 32'(rdDone), 32'(cyc == r_done));
            chk("wrDone", 32'(wrDone), 32'(cyc == w_done));
            chk("rdData", rdData, exp_rd);
`ifdef DATA_MEM_ALIGN_CHECK_EN
            chk("alignErr", 32'(alignErr),
                32'((cyc == w_done && is_mis(1'b1, w_type, w_addr)) ||
                    (cyc == r_done && is_mis(1'b0, 2'd0, r_addr))));
`endif
        end
    end

    task automatic txn(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] t, input int hold, input bit scramble);
        int acc;
        @(negedge clock);
        acc = cyc + 1;
        if (is_wr) begin
            wrReq = 1'b1; wrAddr = a; wrData = d; wrType = t;
            w_addr = a; w_data = d; w_type = t;
            w_acc = acc; w_done = acc + LAT; w_end = acc + LAT + hold;
        end else begin
            rdReq = 1'b1; rdAddr = a;
            r_addr = a;
            r_acc = acc; r_done = acc + LAT; r_end = acc + LAT + hold;
        end
        @(negedge clock);
        if (scramble) begin
            wrAddr = $urandom; wrData = $urandom; wrType = 2'($urandom); rdAddr = $urandom;
        end
        while (cyc < acc + LAT - 1) @(negedge clock);
        chk(is_wr ? "wr_done_early" : "rd_done_early", 32'(is_wr ? wrDone : rdDone), 32'd0);
        @(negedge clock);
        chk(is_wr ? "wr_done_at_lat" : "rd_done_at_lat", 32'(is_wr ? wrDone : rdDone), 32'd1);
        while (cyc < acc + LAT + hold) @(negedge clock);
        if (is_wr) wrReq = 1'b0; else rdReq = 1'b0;
    endtask

    task automatic rd_expect(input string name, input logic [31:0] a, input logic [31:0] lit);
        txn(1'b0, a, 32'h0, 2'd0, 0, 1'b0);
        chk(name, rdData, lit);
    endtask

    task automatic both(input logic [31:0] a, input logic [31:0] d);
        int k;
        @(negedge clock);
        k = cyc;
        wrReq = 1'b1; rdReq = 1'b1; wrAddr = a; wrData = d; wrType = 2'd0; rdAddr = a;
        w_addr = a; w_data = d; w_type = 2'd0; r_addr = a;
        w_acc = k + 1; w_done = k + 1 + LAT; w_end = w_done;
        r_acc = k + 3 + LAT; r_done = r_acc + LAT; r_end = r_done;
        while (cyc < k + 1 + LAT) @(negedge clock);
        chk("both_wr_first", 32'({wrDone, rdDone}), 32'b10);
        wrReq = 1'b0;
        while (cyc < k + 3 + 2*LAT) @(negedge clock);
        rdReq = 1'b0;
        chk("both_rd_value", rdData, d);
    endtask

    task automatic rd_abort(input logic [31:0] a);
        int acc;
        @(negedge clock);
        acc = cyc + 1;
        rdReq = 1'b1; rdAddr = a; r_addr = a;
        r_acc = acc; r_done = acc + LAT; r_end = r_done;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0; rdReq = 1'b0; r_done = -1; r_end = cyc;
        @(negedge clock);
        reset = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rdData", rdData, 32'h0);
        @(negedge clock);
        chk("abort_no_done", 32'(rdDone), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b1;
        chk("reset_busy",   32'(busy),   32'd0);
        chk("reset_rdData", rdData,      32'h0);
        chk("reset_dones",  32'({rdDone, wrDone}), 32'd0);

        txn(1'b1, 32'd8, 32'hDEADBEEF, 2'd0, 0, 1'b0);
        rd_expect("rd8", 32'd8, 32'hDEADBEEF);

        txn(1'b1, 32'd4, 32'h11223344, 2'd0, 0, 1'b0);
        txn(1'b1, 32'd6, 32'h000000AA, 2'd2, 2, 1'b0);
        txn(1'b1, 32'd4, 32'h0000BBCC, 2'd1, 0, 1'b1);
        rd_expect("merge4", 32'd4, 32'h11AABBCC);

        both(32'd20, 32'h12345678);

        txn(1'b1, 32'(4*DEPTH + 12), 32'hCAFEF00D, 2'd0, 0, 1'b0);
        rd_expect("wrap12", 32'd12, 32'hCAFEF00D);

        txn(1'b1, 32'd8, 32'hFFFFFFFF, 2'd3, 0, 1'b0);
        rd_expect("rsvd8", 32'd8, 32'hDEADBEEF);

        txn(1'b1, 32'd5, 32'h55667788, 2'd0, 0, 1'b0);
        txn(1'b1, 32'd3, 32'h00009999, 2'd1, 0, 1'b0);
`ifdef DATA_MEM_ALIGN_CHECK_EN
        rd_expect("mis_w4", 32'd4, 32'h11AABBCC);
        rd_expect("mis_rd7", 32'd7, 32'h0);
        rd_expect("mis_h0", 32'd0, 32'h0);
`else
        rd_expect("mis_w4", 32'd4, 32'h55667788);
        rd_expect("mis_rd7", 32'd7, 32'h55667788);
        rd_expect("mis_h0", 32'd0, 32'h99990000);
`endif

        rd_abort(32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            rd_expect("cleared", 32'(i * 4), 32'h0);
        end

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
